// File: rtl/hv_timing_meter.sv
// Video raster timing meter: measures line/frame geometry from HBLK/VBLK/HSYN/VSYN
// and publishes a 6-tuple once per frame, with change, lock and no-signal flags.
module hv_timing_meter #(
  parameter int HW = 10,
  parameter int VW = 10
) (
  input  logic          PCLK,
  input  logic          RESET_N,
  input  logic          HBLK,
  input  logic          VBLK,
  input  logic          HSYN,
  input  logic          VSYN,
  output logic [HW-1:0] HTOT,
  output logic [HW-1:0] HACT,
  output logic [HW-1:0] HSW,
  output logic [VW-1:0] VTOT,
  output logic [VW-1:0] VACT,
  output logic [VW-1:0] VSW,
  output logic          FRAME,
  output logic          CHG,
  output logic          LOCK,
  output logic          NOSIG
);

  localparam logic [HW-1:0] H_MAX = '1;
  localparam logic [VW-1:0] V_MAX = '1;

  typedef enum logic [1:0] {IDLE, ARMED, MEAS, LOCKED} state_t;

  state_t        state_q;
  logic          hs_prev_q, vs_prev_q, vs_prev_d;
  logic [HW-1:0] hlen_q, hact_q, hsw_q, hlen_d, hact_d, hsw_d;
  logic [VW-1:0] vlen_q, vact_q, vsw_q, vlen_d, vact_d, vsw_d;
  logic [HW-1:0] htot_q, hact_o_q, hsw_o_q;
  logic [VW-1:0] vtot_q, vact_o_q, vsw_o_q;
  logic          frame_q, chg_q, lock_q, nosig_q, pub_q;
  logic          hs_fall, vs_fall, same_tuple, sat_hit;
  logic          h_act, h_syn, v_act, v_syn;

  function automatic logic [HW-1:0] h_acc(input logic [HW-1:0] v, input logic t);
    return (t && (v != H_MAX)) ? v + HW'(1) : v;
  endfunction

  function automatic logic [VW-1:0] v_acc(input logic [VW-1:0] v, input logic t);
    return (t && (v != V_MAX)) ? v + VW'(1) : v;
  endfunction

  always_comb begin
    h_act   = ~HBLK;
    h_syn   = ~HSYN;
    v_act   = ~VBLK;
    v_syn   = ~VSYN;
    hs_fall = hs_prev_q & h_syn;
    vs_fall = hs_fall & vs_prev_q & v_syn;
    hlen_d  = hs_fall ? HW'(1)     : h_acc(hlen_q, 1'b1);
    hact_d  = hs_fall ? HW'(h_act) : h_acc(hact_q, h_act);
    hsw_d   = hs_fall ? HW'(h_syn) : h_acc(hsw_q, h_syn);
    vs_prev_d = vs_prev_q;
    vlen_d  = vlen_q;
    vact_d  = vact_q;
    vsw_d   = vsw_q;
    // Vertical counters advance only on line boundaries, so sub-line VSYN glitches are invisible.
    if (hs_fall) begin
      vs_prev_d = VSYN;
      vlen_d    = vs_fall ? VW'(1)     : v_acc(vlen_q, 1'b1);
      vact_d    = vs_fall ? VW'(v_act) : v_acc(vact_q, v_act);
      vsw_d     = vs_fall ? VW'(v_syn) : v_acc(vsw_q, v_syn);
    end
    same_tuple = ({hlen_q, hact_q, hsw_q, vlen_q, vact_q, vsw_q} ==
                  {htot_q, hact_o_q, hsw_o_q, vtot_q, vact_o_q, vsw_o_q});
    sat_hit = (hlen_d == H_MAX) || (vlen_d == V_MAX);
  end

  always_ff @(posedge PCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      hs_prev_q <= 1'b1;
      vs_prev_q <= 1'b1;
      hlen_q    <= '0;
      hact_q    <= '0;
      hsw_q     <= '0;
      vlen_q    <= '0;
      vact_q    <= '0;
      vsw_q     <= '0;
      htot_q    <= '0;
      hact_o_q  <= '0;
      hsw_o_q   <= '0;
      vtot_q    <= '0;
      vact_o_q  <= '0;
      vsw_o_q   <= '0;
      frame_q   <= 1'b0;
      chg_q     <= 1'b0;
      lock_q    <= 1'b0;
      nosig_q   <= 1'b0;
      pub_q     <= 1'b0;
    end else begin
      hs_prev_q <= HSYN;
      vs_prev_q <= vs_prev_d;
      hlen_q    <= hlen_d;
      hact_q    <= hact_d;
      hsw_q     <= hsw_d;
      vlen_q    <= vlen_d;
      vact_q    <= vact_d;
      vsw_q     <= vsw_d;
      frame_q   <= 1'b0;
      chg_q     <= 1'b0;
      if (sat_hit) begin
        state_q <= IDLE;
        lock_q  <= 1'b0;
        nosig_q <= 1'b1;
      end else if (vs_fall) begin
        case (state_q)
          IDLE: state_q <= ARMED;
          default: begin
            // Counters still hold the frame that just ended; they reload this same edge.
            htot_q   <= hlen_q;
            hact_o_q <= hact_q;
            hsw_o_q  <= hsw_q;
            vtot_q   <= vlen_q;
            vact_o_q <= vact_q;
            vsw_o_q  <= vsw_q;
            frame_q  <= 1'b1;
            chg_q    <= !same_tuple || !pub_q;
            pub_q    <= 1'b1;
            nosig_q  <= 1'b0;
            if (state_q != ARMED && same_tuple) begin
              state_q <= LOCKED;
              lock_q  <= 1'b1;
            end else begin
              state_q <= MEAS;
              lock_q  <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  assign HTOT  = htot_q;
  assign HACT  = hact_o_q;
  assign HSW   = hsw_o_q;
  assign VTOT  = vtot_q;
  assign VACT  = vact_o_q;
  assign VSW   = vsw_o_q;
  assign FRAME = frame_q;
  assign CHG   = chg_q;
  assign LOCK  = lock_q;
  assign NOSIG = nosig_q;

endmodule

// File: tb/tb_hv_timing_meter.sv
// Directed bench for hv_timing_meter using a compact raster: 384-clock lines, 8-line frames
// (VBLK=0 on lines 0..5, VSYN=0 on lines 5..6) so each frame publishes 384/289/31 x 8/6/2.
module tb_hv_timing_meter;
  localparam int HW = 10;
  localparam int VW = 10;

  logic PCLK = 1'b0, RESET_N = 1'b0;
  logic HBLK = 1'b1, VBLK = 1'b1, HSYN = 1'b1, VSYN = 1'b1;
  logic [HW-1:0] HTOT, HACT, HSW;
  logic [VW-1:0] VTOT, VACT, VSW;
  logic FRAME, CHG, LOCK, NOSIG;

  int checks = 0;
  int errors = 0;
  int frame_cnt = 0;
  int cur_line = 0, cur_clk = 0;
  int cap_line = 0, cap_clk = 0;
  logic [HW-1:0] cap_htot, cap_hact, cap_hsw;
  logic [VW-1:0] cap_vtot, cap_vact, cap_vsw;
  logic cap_chg, cap_lock, cap_nosig;

  hv_timing_meter #(.HW(HW), .VW(VW)) dut (
    .PCLK(PCLK), .RESET_N(RESET_N), .HBLK(HBLK), .VBLK(VBLK), .HSYN(HSYN), .VSYN(VSYN),
    .HTOT(HTOT), .HACT(HACT), .HSW(HSW), .VTOT(VTOT), .VACT(VACT), .VSW(VSW),
    .FRAME(FRAME), .CHG(CHG), .LOCK(LOCK), .NOSIG(NOSIG)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Capture every published set, one line per publish.
  always @(posedge PCLK) begin
    #1;
    if (FRAME === 1'b1) begin
      frame_cnt++;
      cap_htot = HTOT; cap_hact = HACT; cap_hsw = HSW;
      cap_vtot = VTOT; cap_vact = VACT; cap_vsw = VSW;
      cap_chg = CHG; cap_lock = LOCK; cap_nosig = NOSIG;
      cap_line = cur_line; cap_clk = cur_clk;
      $display("publish %0d: HTOT=%0d HACT=%0d HSW=%0d VTOT=%0d VACT=%0d VSW=%0d CHG=%0b LOCK=%0b NOSIG=%0b",
               frame_cnt, HTOT, HACT, HSW, VTOT, VACT, VSW, CHG, LOCK, NOSIG);
    end
  end

  task automatic run_line(input int line, input int c0, input int len, input bit glitch);
    for (int c = c0; c < len; c++) begin
      @(negedge PCLK);
      cur_line = line;
      cur_clk  = c;
      HBLK = !(c >= 2 && c <= 290);
      HSYN = !(c >= 312 && c <= 342);
      VBLK = !(line <= 5);
      VSYN = !(line == 5 || line == 6);
      if (glitch && c >= 100 && c <= 110) VSYN = 1'b0;
    end
  endtask

  task automatic run_frame(input int len);
    for (int l = 0; l < 8; l++) run_line(l, 0, len, 1'b0);
  endtask

  task automatic test_reset;
    #3;
    checks++; if ({HTOT, HACT, HSW, VTOT, VACT, VSW} !== '0) begin errors++;
      $display("FAIL reset_counts: got %h, expected 0", {HTOT, HACT, HSW, VTOT, VACT, VSW}); end
    checks++; if ({FRAME, CHG, LOCK, NOSIG} !== 4'b0000) begin errors++;
      $display("FAIL reset_flags: got %b, expected 0000", {FRAME, CHG, LOCK, NOSIG}); end
    repeat (2) @(negedge PCLK);
    RESET_N = 1'b1;
  endtask

  task automatic test_basic;
    int f0;
    f0 = frame_cnt;
    run_frame(384);
    checks++; if (frame_cnt !== f0) begin errors++;
      $display("FAIL basic_armed_nopub: got %0d frames, expected %0d", frame_cnt, f0); end
    run_frame(384);
    checks++; if (frame_cnt !== f0 + 1) begin errors++;
      $display("FAIL basic_first_pub: got %0d frames, expected %0d", frame_cnt, f0 + 1); end
    checks++; if ({cap_htot, cap_hact, cap_hsw} !== {10'd384, 10'd289, 10'd31}) begin errors++;
      $display("FAIL basic_h: got %0d/%0d/%0d, expected 384/289/31", cap_htot, cap_hact, cap_hsw); end
    checks++; if ({cap_vtot, cap_vact, cap_vsw} !== {10'd8, 10'd6, 10'd2}) begin errors++;
      $display("FAIL basic_v: got %0d/%0d/%0d, expected 8/6/2", cap_vtot, cap_vact, cap_vsw); end
    checks++; if ({cap_chg, cap_lock, cap_nosig} !== 3'b100) begin errors++;
      $display("FAIL basic_flags1: got chg/lock/nosig=%b, expected 100", {cap_chg, cap_lock, cap_nosig}); end
    checks++; if (cap_line !== 5 || cap_clk !== 312) begin errors++;
      $display("FAIL basic_latency: got line %0d clk %0d, expected line 5 clk 312", cap_line, cap_clk); end
    run_frame(384);
    checks++; if (frame_cnt !== f0 + 2) begin errors++;
      $display("FAIL basic_second_pub: got %0d frames, expected %0d", frame_cnt, f0 + 2); end
    checks++; if ({cap_chg, cap_lock} !== 2'b01) begin errors++;
      $display("FAIL basic_lock: got chg/lock=%b, expected 01", {cap_chg, cap_lock}); end
    checks++; if (FRAME !== 1'b0 || LOCK !== 1'b1) begin errors++;
      $display("FAIL basic_hold: got FRAME=%b LOCK=%b, expected 0 1", FRAME, LOCK); end
  endtask

  task automatic test_line_change;
    run_frame(400);
    checks++; if (cap_htot !== 10'd400 || cap_hact !== 10'd289) begin errors++;
      $display("FAIL chg_htot: got %0d/%0d, expected 400/289", cap_htot, cap_hact); end
    checks++; if ({cap_chg, cap_lock} !== 2'b10) begin errors++;
      $display("FAIL chg_unlock: got chg/lock=%b, expected 10", {cap_chg, cap_lock}); end
    run_frame(400);
    checks++; if ({cap_chg, cap_lock} !== 2'b01) begin errors++;
      $display("FAIL chg_relock: got chg/lock=%b, expected 01", {cap_chg, cap_lock}); end
    run_frame(384);
    checks++; if (cap_htot !== 10'd384 || {cap_chg, cap_lock} !== 2'b10) begin errors++;
      $display("FAIL chg_back: got htot=%0d chg/lock=%b, expected 384 10", cap_htot, {cap_chg, cap_lock}); end
    run_frame(384);
    checks++; if (cap_lock !== 1'b1) begin errors++;
      $display("FAIL chg_back_lock: got lock=%b, expected 1", cap_lock); end
  endtask

  task automatic test_vsync_glitch;
    int f0;
    f0 = frame_cnt;
    for (int l = 0; l < 8; l++) run_line(l, 0, 384, l == 3);
    checks++; if (frame_cnt !== f0 + 1) begin errors++;
      $display("FAIL glitch_frames: got %0d, expected %0d", frame_cnt, f0 + 1); end
    checks++; if (cap_vtot !== 10'd8 || cap_vsw !== 10'd2) begin errors++;
      $display("FAIL glitch_v: got vtot=%0d vsw=%0d, expected 8 2", cap_vtot, cap_vsw); end
    checks++; if ({cap_chg, cap_lock, LOCK} !== 3'b011) begin errors++;
      $display("FAIL glitch_lock: got chg/lock/LOCK=%b, expected 011", {cap_chg, cap_lock, LOCK}); end
  endtask

  task automatic test_nosig;
    int f0;
    f0 = frame_cnt;
    // hlen is 72 after the last line; 951 more samples reach 1023.
    repeat (950) begin @(negedge PCLK); HSYN = 1'b1; HBLK = 1'b1; end
    @(posedge PCLK); #1;
    checks++; if (NOSIG !== 1'b0) begin errors++;
      $display("FAIL nosig_early: got %b, expected 0", NOSIG); end
    @(negedge PCLK); HSYN = 1'b1;
    @(posedge PCLK); #1;
    checks++; if ({NOSIG, LOCK} !== 2'b10 || HTOT !== 10'd384) begin errors++;
      $display("FAIL nosig_sat: got nosig/lock=%b htot=%0d, expected 10 384", {NOSIG, LOCK}, HTOT); end
    checks++; if (frame_cnt !== f0) begin errors++;
      $display("FAIL nosig_nopub: got %0d frames, expected %0d", frame_cnt, f0); end
    run_frame(384);
    checks++; if (frame_cnt !== f0 || NOSIG !== 1'b1) begin errors++;
      $display("FAIL resume_armed: got frames=%0d nosig=%b, expected %0d 1", frame_cnt, NOSIG, f0); end
    run_frame(384);
    checks++; if (frame_cnt !== f0 + 1 || cap_nosig !== 1'b0 || NOSIG !== 1'b0) begin errors++;
      $display("FAIL resume_pub: got frames=%0d nosig=%b, expected %0d 0", frame_cnt, NOSIG, f0 + 1); end
    checks++; if (cap_lock !== 1'b0 || cap_htot !== 10'd384) begin errors++;
      $display("FAIL resume_vals: got lock=%b htot=%0d, expected 0 384", cap_lock, cap_htot); end
    run_frame(384);
    checks++; if (cap_lock !== 1'b1) begin errors++;
      $display("FAIL resume_lock: got %b, expected 1", cap_lock); end
  endtask

  task automatic test_saturate;
    int f0;
    f0 = frame_cnt;
    run_frame(1100);
    checks++; if (frame_cnt !== f0) begin errors++;
      $display("FAIL sat_nopub: got %0d frames, expected %0d", frame_cnt, f0); end
    checks++; if ({NOSIG, LOCK} !== 2'b10 || HTOT !== 10'd384) begin errors++;
      $display("FAIL sat_flags: got nosig/lock=%b htot=%0d, expected 10 384", {NOSIG, LOCK}, HTOT); end
  endtask

  task automatic test_reset_mid;
    int f0;
    run_line(0, 0, 384, 1'b0);
    run_line(1, 0, 384, 1'b0);
    run_line(2, 0, 100, 1'b0);
    #2 RESET_N = 1'b0;
    #1;
    checks++; if ({HTOT, HACT, HSW, VTOT, VACT, VSW} !== '0) begin errors++;
      $display("FAIL rstmid_counts: got %h, expected 0", {HTOT, HACT, HSW, VTOT, VACT, VSW}); end
    checks++; if ({FRAME, CHG, LOCK, NOSIG} !== 4'b0000) begin errors++;
      $display("FAIL rstmid_flags: got %b, expected 0000", {FRAME, CHG, LOCK, NOSIG}); end
    @(negedge PCLK);
    RESET_N = 1'b1;
    f0 = frame_cnt;
    run_line(2, 100, 384, 1'b0);
    for (int l = 3; l < 8; l++) run_line(l, 0, 384, 1'b0);
    checks++; if (frame_cnt !== f0) begin errors++;
      $display("FAIL rstmid_armed: got %0d frames, expected %0d", frame_cnt, f0); end
    run_frame(384);
    checks++; if (frame_cnt !== f0 + 1 || cap_chg !== 1'b1) begin errors++;
      $display("FAIL rstmid_pub: got frames=%0d chg=%b, expected %0d 1", frame_cnt, cap_chg, f0 + 1); end
    checks++; if (cap_htot !== 10'd384 || cap_vtot !== 10'd8) begin errors++;
      $display("FAIL rstmid_vals: got %0d/%0d, expected 384/8", cap_htot, cap_vtot); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_line_change;
    test_vsync_glitch;
    test_nosig;
    test_saturate;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hv_timing_meter.md
Name: hv_timing_meter

Overview:
- Measures video timing from the raster signals the core's timing generator drives (HBLK, VBLK, HSYN, VSYN).
- Reports line total, active pixels, hsync width, frame total lines, active lines and vsync width, plus a lock flag.
- Sits alongside the video path on the pixel clock. Used for on-screen diagnostics and for the bench check of generator timing per game model.

Parameters:
- HW, 10, width of horizontal counters (pixels); saturates at 2^HW-1.
- VW, 10, width of vertical counters (lines); saturates at 2^VW-1.

Ports:
- PCLK  in  1  pixel clock; every rising edge is one pixel sample.
- RESET_N  in  1  asynchronous, active-low reset.
- HBLK  in  1  horizontal blank, 1 = blanked.
- VBLK  in  1  vertical blank, 1 = blanked.
- HSYN  in  1  horizontal sync, active-low.
- VSYN  in  1  vertical sync, active-low.
- HTOT  out  HW  pixels per line (HSYN fall to HSYN fall).
- HACT  out  HW  samples with HBLK=0 in the line.
- HSW  out  HW  samples with HSYN=0 in the line.
- VTOT  out  VW  lines per frame (VSYN fall to VSYN fall).
- VACT  out  VW  lines with VBLK=0.
- VSW  out  VW  lines with VSYN=0.
- FRAME  out  1  one-cycle strobe when a frame result is published.
- CHG  out  1  one-cycle strobe when a published set differs from the previous set.
- LOCK  out  1  timing stable.
- NOSIG  out  1  no HSYN edge or no VSYN edge within counter range.

Behaviour:
- Reset (async, RESET_N=0): all outputs 0, all counters 0, state IDLE, previous-sample registers = 1.
- Horizontal:
  - hs_fall = previous HSYN sample 1 and current sample 0.
  - hlen: on hs_fall load 1, otherwise increment, saturating.
  - hact/hsw accumulators: on hs_fall load (HBLK==0)/(HSYN==0), otherwise add the same term, saturating.
  - On hs_fall, line_cap = {hlen, hact, hsw} (these are the values of the line just ended).
- Vertical (evaluated only on hs_fall samples):
  - vs_fall = VSYN sampled at the previous hs_fall was 1 and is 0 now.
  - vlen counts hs_fall events the same way as hlen (load 1 on vs_fall).
  - vact/vsw accumulate (VBLK==0)/(VSYN==0) sampled at each hs_fall; on vs_fall they reload with the current term.
- Publish: on vs_fall in states MEAS or LOCKED:
  - Registered outputs update 1 cycle after the hs_fall sample: HTOT/HACT/HSW = line_cap, VTOT/VACT/VSW = {vlen, vact, vsw}.
  - FRAME pulses high for that same cycle.
  - CHG pulses in that same cycle if the new 6-tuple differs from the previous published tuple. The very first publish counts as a change.
- State machine:
  - IDLE -> ARMED on first vs_fall. Nothing is published; the counts of this partial frame are discarded.
  - ARMED -> MEAS on the next vs_fall, with publish.
  - MEAS -> LOCKED on a vs_fall whose tuple equals the previous one. LOCK = 1 from the publish cycle.
  - LOCKED -> MEAS on a vs_fall whose tuple differs. LOCK = 0 and CHG = 1 in the same cycle.
  - Any state -> IDLE when hlen or vlen reaches saturation: LOCK = 0, NOSIG = 1.
  - Outputs other than LOCK and FRAME hold their last values in IDLE.
- NOSIG clears on the next publish.
- Saturation is sticky until the next load. No wrap-around is permitted.
- HSYN held high forever: hlen saturates at cycle 2^HW-1 -> NOSIG.
- RESET_N asserted mid-frame: immediate clear. Restart requires IDLE -> ARMED -> MEAS again (two vs_falls before the first FRAME).
- Latency: counts reflect the frame ending at the vs_fall sample; outputs valid 1 cycle later.

Test Plan:
- Line 384 clocks, HBLK=0 on clocks 2..290, HSYN=0 on clocks 312..342. Frame 263 lines, VBLK=0 on lines 0..223, VSYN=0 on lines 235..241 -> after the 2nd vs_fall: HTOT=384, HACT=289, HSW=31, VTOT=263, VACT=224, VSW=7, FRAME=1, CHG=1, LOCK=0. After the 3rd: LOCK=1, CHG=0.
- Locked at 384x263, then switch the line to 400 clocks -> next publish HTOT=400, CHG=1, LOCK=0. The following frame -> LOCK=1.
- Stop HSYN (held 1) while locked -> after 1023 cycles NOSIG=1, LOCK=0, HTOT still 384. Resume -> no FRAME until the 2nd vs_fall, then NOSIG=0.
- Pulse RESET_N low mid-frame -> all outputs 0 immediately. First FRAME only at the 2nd subsequent vs_fall.
- VSYN low for 0 lines between hs_falls (glitch not spanning an hs_fall) -> no vs_fall detected, VTOT unchanged, LOCK stays 1.
- Line 1100 clocks with HW=10 -> hlen saturates at 1023 -> IDLE, NOSIG=1, no publish.
